// File: rtl/wb_stage_pkg.sv
// Shared pipeline definitions for the RV64 write-back path: widths, the
// write-back source encoding and the MEM/WB register bundle.
package wb_stage_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_sel_t;

  // Field layout of the MEM/WB pipeline register, owned by the pipeline-register module.
  typedef struct packed {
    logic              reg_write;
    wb_sel_t           wb_sel;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   read_data;
    logic [REG_AW-1:0] rd;
  } mem_wb_t;

endpackage

// File: rtl/wb_stage_mux.sv
// Parameterised 2:1 datapath mux; also used by the EX-stage forwarding muxes.
module wb_mux #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);

  // Plain ternary so an unknown select propagates as X rather than being masked.
  assign y = sel ? b : a;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects the retiring result, gates x0 writes and keeps a
// saturating count of effective register writes.
module wb_stage #(
  parameter int XLEN   = wb_stage_pkg::XLEN,
  parameter int REG_AW = wb_stage_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic              MemToRegW,
  input  logic [XLEN-1:0]   ALU_ResultW,
  input  logic [XLEN-1:0]   ReadDataW,
  input  logic [REG_AW-1:0] RD_W,
  output logic [XLEN-1:0]   WriteData,
  output logic              RegWriteOut,
  output logic [REG_AW-1:0] RdOut,
  output logic [63:0]       WbCount
);
  import wb_stage_pkg::*;

  localparam int CNT_W = 64;

  wb_sel_t           wb_sel;
  logic [XLEN-1:0]   mux_out;
  logic              write_en;
  logic [CNT_W-1:0]  count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign wb_sel = wb_sel_t'(MemToRegW);

  wb_mux #(.W(XLEN)) u_mux (
    .a   (ALU_ResultW),
    .b   (ReadDataW),
    .sel (wb_sel == WB_MEM),
    .y   (mux_out)
  );

  assign write_en = RegWriteW && (RD_W != '0);

  // Outputs are combinational but forced to zero while reset is held.
  assign WriteData   = rst ? '0 : mux_out;
  assign RegWriteOut = rst ? 1'b0 : write_en;
  assign RdOut       = rst ? '0 : RD_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (write_en) begin
      count <= sat_inc(count);
    end
  end

  assign WbCount = count;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboarded random and directed bench for wb_stage.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        RegWriteW;
  logic        MemToRegW;
  logic [63:0] ALU_ResultW;
  logic [63:0] ReadDataW;
  logic [4:0]  RD_W;
  logic [63:0] WriteData;
  logic        RegWriteOut;
  logic [4:0]  RdOut;
  logic [63:0] WbCount;

  wb_stage dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteW   (RegWriteW),
    .MemToRegW   (MemToRegW),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .RD_W        (RD_W),
    .WriteData   (WriteData),
    .RegWriteOut (RegWriteOut),
    .RdOut       (RdOut),
    .WbCount     (WbCount)
  );

  typedef struct {
    logic [63:0] wd;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] model_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("WriteData",   WriteData,          e.wd);
      chk("RegWriteOut", {63'd0, RegWriteOut}, {63'd0, e.we});
      chk("RdOut",       {59'd0, RdOut},     {59'd0, e.rd});
      chk("WbCount",     WbCount,            e.cnt);
    end
  end

  // Drive one cycle's inputs just after the rising edge and record the expectation.
  task automatic drive(input logic r, input logic rw, input logic m2r,
                       input logic [63:0] alu, input logic [63:0] rdata,
                       input logic [4:0] rd);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    RegWriteW   = rw;
    MemToRegW   = m2r;
    ALU_ResultW = alu;
    ReadDataW   = rdata;
    RD_W        = rd;
    if (r) begin
      model_cnt = 0;
      e.wd = 64'd0; e.we = 1'b0; e.rd = 5'd0; e.cnt = 64'd0;
    end else begin
      e.wd  = m2r ? rdata : alu;
      e.we  = rw && (rd != 5'd0);
      e.rd  = rd;
      e.cnt = model_cnt;
    end
    sb.push_back(e);
    if (!r && e.we && model_cnt != 64'hFFFF_FFFF_FFFF_FFFF)
      model_cnt = model_cnt + 1;
  endtask

  initial begin
    rst = 1'b1; RegWriteW = 1'b0; MemToRegW = 1'b0;
    ALU_ResultW = '0; ReadDataW = '0; RD_W = '0;

    // Reset state, with live inputs to confirm the gating.
    drive(1, 1, 1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 5'd7);
    drive(1, 1, 0, 64'hDEAD_BEEF_0000_0001, 64'h0, 5'd3);

    // Directed test-plan sequence.
    drive(0, 0, 0, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 5'd10);
    drive(0, 1, 0, 64'hA1B2_C3D4_E5F6_0789, 64'hFEDC_BA98_7654_3210, 5'd10);
    drive(0, 1, 0, 64'hA1B2_C3D4_E5F6_0789, 64'hFEDC_BA98_7654_3210, 5'd10);
    drive(0, 1, 1, 64'hA1B2_C3D4_E5F6_0789, 64'h0F1E_2D3C_4B5A_6978, 5'd10);
    drive(0, 0, 1, 64'hA1B2_C3D4_E5F6_0789, 64'h0F1E_2D3C_4B5A_6978, 5'd10);
    drive(0, 1, 1, 64'hA1B2_C3D4_E5F6_0789, 64'h0F1E_2D3C_4B5A_6978, 5'd0);
    drive(0, 1, 0, 64'h0BAD_F00D_CAFE_0000, 64'h0F1E_2D3C_4B5A_6978, 5'd0);
    drive(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd31);
    drive(0, 1, 1, 64'h0, 64'h8000_0000_0000_0000, 5'd1);

    // Randomised traffic, biased so x0 and disabled writes show up often.
    for (int i = 0; i < 150; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      drive(0, 1'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, rd);
    end

    // Three writes, then reset asserted between edges, then recovery.
    drive(0, 1, 0, 64'h1, 64'h2, 5'd4);
    drive(0, 1, 1, 64'h3, 64'h4, 5'd5);
    drive(0, 1, 0, 64'h5, 64'h6, 5'd6);
    drive(1, 1, 1, 64'h7, 64'h8, 5'd9);
    drive(1, 1, 0, 64'h9, 64'hA, 5'd9);
    drive(0, 1, 0, 64'hB, 64'hC, 5'd12);
    drive(0, 0, 0, 64'hD, 64'hE, 5'd12);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

The write-back stage is the final stage of the five-stage RV64 pipeline. It picks the architectural result for the retiring instruction, either the ALU result or the memory load data, and presents it on `WriteData`. It also drives the register-file write port (enable and destination address) and the forwarding bus back to the hazard unit. It keeps a saturating count of register write-backs for performance monitoring.

## Interface
Parameters:
- `XLEN`, 64, datapath width.
- `REG_AW`, 5, register-address width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `RegWriteW`  in  1  MEM/WB control bit: the instruction writes a register.
- `MemToRegW`  in  1  MEM/WB control bit: 1 selects load data, 0 selects the ALU result.
- `ALU_ResultW`  in  XLEN  ALU result latched in MEM/WB.
- `ReadDataW`  in  XLEN  data-memory read data latched in MEM/WB.
- `RD_W`  in  REG_AW  destination register index.
- `WriteData`  out  XLEN  selected write-back value.
- `RegWriteOut`  out  1  register-file write enable.
- `RdOut`  out  REG_AW  register-file write address; also the forwarding tag.
- `WbCount`  out  64  number of effective register writes since reset.

## Operation
- `WriteData` = `MemToRegW` ? `ReadDataW` : `ALU_ResultW`.
  - Purely combinational.
  - Independent of `RegWriteW`: the value is driven even when no write occurs.
- `RegWriteOut` = `RegWriteW` and (`RD_W` != 0).
  - Writes to x0 are suppressed here, so the register file and forwarding logic never see an x0 write.
- `RdOut` = `RD_W`, passed through combinationally.
- `WbCount`:
  - Increments by 1 on each rising edge of `clk` where `RegWriteOut` = 1.
  - Saturates at 2^64−1; it does not wrap.
- While `rst` = 1:
  - `WriteData` = 0, `RegWriteOut` = 0, `RdOut` = 0.
  - `WbCount` is cleared.
  - This gating applies even though the outputs are otherwise combinational.
- X on `MemToRegW` must not be masked: the output follows standard mux semantics.

## Timing
- `WriteData`, `RegWriteOut` and `RdOut`: zero-cycle latency from the inputs, valid in the same cycle.
- The register file captures on the next rising edge of `clk`, or uses its write-first/half-cycle scheme; that behaviour is external to this block.
- `WbCount`:
  - Registered; its value reflects writes completed up to the previous edge.
  - Reset value is 0.
  - Asserting `rst` mid-operation clears it immediately, independent of `clk`.
  - After `rst` deasserts, the first rising edge with `RegWriteOut` = 1 makes it 1.
- There is no handshake and no stall input. Stalls and bubbles arrive as `RegWriteW` = 0 from the MEM/WB register.
- The block adds no pipeline register; MEM/WB is owned by the pipeline-register module.

## Structure
- Shared pipeline package holds:
  - `XLEN` and `REG_AW` constants.
  - The `wb_sel_t` encoding: `WB_ALU` = 0, `WB_MEM` = 1.
  - The MEM/WB bundle typedef.
- One sub-module, `wb_mux`: a parameterised 2:1 XLEN mux, reused by the EX forwarding muxes.
- The counter and the x0 gate stay inline in this block.

## Test plan
- Write disabled, ALU selected:
  - Stimulus: `RegWriteW`=0, `MemToRegW`=0, `ALU_ResultW`=0x123456789ABCDEF0, `ReadDataW`=0xFEDCBA9876543210, `RD_W`=10.
  - Response: `WriteData`=0x123456789ABCDEF0, `RegWriteOut`=0, `WbCount` unchanged.
- ALU write-back:
  - Stimulus: `RegWriteW`=1, `MemToRegW`=0, `ALU_ResultW`=0xA1B2C3D4E5F60789, `RD_W`=10.
  - Response: `WriteData`=0xA1B2C3D4E5F60789, `RegWriteOut`=1, `RdOut`=10, `WbCount` +1 per edge.
- Load write-back:
  - Stimulus: `MemToRegW`=1, `ReadDataW`=0x0F1E2D3C4B5A6978.
  - Response: `WriteData`=0x0F1E2D3C4B5A6978.
- Load selected, write disabled:
  - Stimulus: `RegWriteW`=0, `MemToRegW`=1.
  - Response: `WriteData` still 0x0F1E2D3C4B5A6978, `RegWriteOut`=0, `WbCount` holds.
- x0 write:
  - Stimulus: `RegWriteW`=1, `RD_W`=0.
  - Response: `RegWriteOut`=0, `WbCount` holds, `WriteData` still follows the mux.
- Async reset:
  - Stimulus: assert `rst` between clock edges after 3 writes.
  - Response: `WbCount`=0 and all outputs 0 immediately.
  - Then: after deassert, one write gives `WbCount`=1.
